// File: rtl/keypad_scanner_4x4.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner_4x4
// Brief    : Column-scans a 4x4 active-low keypad on a divided tick, debounces
//            the selected row and reports one key code per debounced press.
//            Define KEYPAD_REPEAT_EN to add auto-repeat while a key is held.
// Revision : 1.0  initial release
// ============================================================================
module keypad_scanner_4x4 #(
  parameter logic [15:0] CLK_DIV        = 16'd49999,
  parameter logic [7:0]  DEBOUNCE_TICKS = 8'd20,
  parameter logic [15:0] REPEAT_DELAY   = 16'd500,
  parameter logic [15:0] REPEAT_RATE    = 16'd100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam logic [2:0] c_st_idle     = 3'd0;
  localparam logic [2:0] c_st_scan     = 3'd1;
  localparam logic [2:0] c_st_debounce = 3'd2;
  localparam logic [2:0] c_st_pressed  = 3'd3;
  localparam logic [2:0] c_st_release  = 3'd4;

  localparam logic [7:0] c_cnt_last = DEBOUNCE_TICKS - 8'd1;

  if (DEBOUNCE_TICKS == 8'd0 || REPEAT_DELAY == 16'd0 || REPEAT_RATE == 16'd0) begin : g_bad_cfg
    $error("keypad_scanner_4x4: DEBOUNCE_TICKS, REPEAT_DELAY and REPEAT_RATE must be nonzero");
  end

  logic [15:0] r_div;
  logic        w_tick;
  logic [3:0]  r_rows_m;
  logic [3:0]  r_rows_s;
  logic [2:0]  r_state;
  logic [1:0]  r_col_idx;
  logic [1:0]  r_row_idx;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_inc;
  logic        w_cnt_done;
  logic        w_any_low;
  logic        w_row_low;
  logic [1:0]  w_low_row;

  assign w_tick     = (r_div == CLK_DIV);
  assign w_any_low  = (r_rows_s != 4'hF);
  assign w_row_low  = ~r_rows_s[r_row_idx];
  assign w_cnt_inc  = r_cnt + 8'd1;
  // ">=" keeps DEBOUNCE_TICKS == 1 well defined (c_cnt_last is 0 there).
  assign w_cnt_done = (w_cnt_inc >= c_cnt_last);

  always_comb begin
    w_low_row = 2'd0;
    casez (r_rows_s)
      4'b???0: w_low_row = 2'd0;
      4'b??01: w_low_row = 2'd1;
      4'b?011: w_low_row = 2'd2;
      4'b0111: w_low_row = 2'd3;
      default: w_low_row = 2'd0;
    endcase
  end

  always_comb begin
    col_out = (r_state == c_st_idle) ? 4'b0000 : ~(4'b0001 << r_col_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= 16'd0;
    end else if (w_tick) begin
      r_div <= 16'd0;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows_m <= 4'hF;
      r_rows_s <= 4'hF;
    end else begin
      r_rows_m <= row_in;
      r_rows_s <= r_rows_m;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  logic [15:0] r_rep_cnt;
  logic        r_rep_first;
  logic [15:0] w_rep_inc;
  logic        w_rep_hit;

  assign w_rep_inc = r_rep_cnt + 16'd1;
  assign w_rep_hit = (w_rep_inc == (r_rep_first ? REPEAT_DELAY : REPEAT_RATE));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_col_idx   <= 2'd0;
      r_row_idx   <= 2'd0;
      r_cnt       <= 8'd0;
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_down    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= 16'd0;
      r_rep_first <= 1'b1;
`endif
    end else begin
      key_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          c_st_idle: begin
            if (w_any_low) begin
              r_state   <= c_st_scan;
              r_col_idx <= 2'd0;
            end
          end
          c_st_scan: begin
            if (w_any_low) begin
              r_row_idx <= w_low_row;
              r_cnt     <= 8'd0;
              r_state   <= c_st_debounce;
            end else if (r_col_idx == 2'd3) begin
              r_state <= c_st_idle;
            end else begin
              r_col_idx <= r_col_idx + 2'd1;
            end
          end
          c_st_debounce: begin
            if (!w_row_low) begin
              r_cnt   <= 8'd0;
              r_state <= c_st_idle;
            end else if (w_cnt_done) begin
              r_cnt       <= 8'd0;
              r_state     <= c_st_pressed;
              key_code    <= {r_row_idx, r_col_idx};
              key_valid   <= 1'b1;
              key_down    <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
              r_rep_cnt   <= 16'd0;
              r_rep_first <= 1'b1;
`endif
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          c_st_pressed: begin
            if (!w_row_low) begin
              r_cnt   <= 8'd0;
              r_state <= c_st_release;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (w_rep_hit) begin
              key_valid   <= 1'b1;
              r_rep_cnt   <= 16'd0;
              r_rep_first <= 1'b0;
            end else begin
              r_rep_cnt <= w_rep_inc;
            end
`endif
          end
          c_st_release: begin
            if (w_row_low) begin
              // Bounce on release: resume the hold without a new report.
              r_cnt       <= 8'd0;
              r_state     <= c_st_pressed;
`ifdef KEYPAD_REPEAT_EN
              r_rep_cnt   <= 16'd0;
              r_rep_first <= 1'b1;
`endif
            end else if (w_cnt_done) begin
              r_cnt    <= 8'd0;
              r_state  <= c_st_idle;
              key_down <= 1'b0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= c_st_idle;
            r_cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner_4x4.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner_4x4
// Brief    : Self-checking bench for keypad_scanner_4x4 with a keypad matrix
//            model and a tick-level behavioural reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scanner_4x4;

  localparam logic [15:0] P_CLK_DIV  = 16'd3;
  localparam logic [7:0]  P_DEBOUNCE = 8'd4;
  localparam logic [15:0] P_RDELAY   = 16'd5;
  localparam logic [15:0] P_RRATE    = 16'd2;
  localparam int TICK_CLKS = 4;
  localparam int DEB       = 4;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_SCAN = 1, M_DEB = 2, M_HELD = 3, M_REL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] pressed = 16'h0;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic prev_valid = 1'b0;

  keypad_scanner_4x4 #(
    .CLK_DIV(P_CLK_DIV), .DEBOUNCE_TICKS(P_DEBOUNCE),
    .REPEAT_DELAY(P_RDELAY), .REPEAT_RATE(P_RRATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] keypad_rows(input logic [15:0] keys, input logic [3:0] cols);
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
    return rows;
  endfunction

  function automatic int lowest_zero(input logic [3:0] rows);
    int res;
    res = 0;
    for (int r = 3; r >= 0; r--) if (!rows[r]) res = r;
    return res;
  endfunction

  always_comb row_in = keypad_rows(pressed, col_out);

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stable-run counting per tick on rows seen two clocks late.
  int         m_mode, m_col, m_row, m_run, m_held, m_next, m_edges;
  logic [3:0] m_h1, m_h2;
  logic [3:0] exp_col, exp_code;
  logic       exp_valid, exp_down;

  task automatic model_reset();
    m_mode = M_IDLE; m_col = 0; m_row = 0; m_run = 0; m_held = 0;
    m_next = int'(P_RDELAY); m_edges = 0; m_h1 = 4'hF; m_h2 = 4'hF;
    exp_col = 4'b0000; exp_code = 4'h0; exp_valid = 1'b0; exp_down = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] rows;
    bit tick;
    rows = m_h2;
    m_h2 = m_h1;
    m_h1 = keypad_rows(pressed, exp_col);
    tick = (m_edges % TICK_CLKS) == TICK_CLKS - 1;
    m_edges++;
    exp_valid = 1'b0;
    if (tick) begin
      case (m_mode)
        M_IDLE: if (rows != 4'hF) begin m_mode = M_SCAN; m_col = 0; end
        M_SCAN: begin
          if (rows != 4'hF) begin
            m_row = lowest_zero(rows); m_run = 1; m_mode = M_DEB;
          end else if (m_col == 3) m_mode = M_IDLE;
          else m_col++;
        end
        M_DEB: begin
          if (!rows[m_row]) begin
            m_run++;
            if (m_run >= DEB) begin
              m_mode = M_HELD; exp_code = 4'(m_row * 4 + m_col);
              exp_valid = 1'b1; exp_down = 1'b1; m_held = 0; m_next = int'(P_RDELAY);
            end
          end else m_mode = M_IDLE;
        end
        M_HELD: begin
          if (rows[m_row]) begin
            m_mode = M_REL; m_run = 1;
          end else if (REPEAT_ON) begin
            m_held++;
            if (m_held == m_next) begin exp_valid = 1'b1; m_held = 0; m_next = int'(P_RRATE); end
          end
        end
        default: begin
          if (rows[m_row]) begin
            m_run++;
            if (m_run >= DEB) begin m_mode = M_IDLE; exp_down = 1'b0; end
          end else begin
            m_mode = M_HELD; m_held = 0; m_next = int'(P_RDELAY);
          end
        end
      endcase
    end
    exp_col = (m_mode == M_IDLE) ? 4'b0000 : ~(4'b0001 << m_col);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("col_out", {12'h0, col_out}, {12'h0, exp_col});
        check("key_code", {12'h0, key_code}, {12'h0, exp_code});
        check("key_valid", {15'h0, key_valid}, {15'h0, exp_valid});
        check("key_down", {15'h0, key_down}, {15'h0, exp_down});
        check("valid_single", {15'h0, key_valid & prev_valid}, 16'h0);
        if (key_valid) pulses++;
        prev_valid = key_valid;
      end else prev_valid = 1'b0;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * TICK_CLKS) @(negedge clk);
  endtask

  task automatic wait_pulse(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 * TICK_CLKS && !got; k++) begin
      @(negedge clk);
      if (key_valid) got = 1'b1;
    end
    check({name, "_pulse_seen"}, {15'h0, got}, 16'h1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_col_out", {12'h0, col_out}, 16'h0);
    check("rst_key_code", {12'h0, key_code}, 16'h0);
    check("rst_key_valid", {15'h0, key_valid}, 16'h0);
    check("rst_key_down", {15'h0, key_down}, 16'h0);
    #2 rst_n = 1'b1;
    wait_ticks(4);
    check("idle_col_out", {12'h0, col_out}, 16'h0);

    // Clean press of row 2, col 1
    pulses = 0;
    pressed = 16'h1 << 9;
    wait_pulse("clean");
    wait_ticks(9);
`ifndef KEYPAD_REPEAT_EN
    check("clean_pulses", pulses[15:0], 16'd1);
`endif
    check("clean_code", {12'h0, key_code}, 16'h9);
    check("clean_model_code", {12'h0, exp_code}, 16'h9);
    check("clean_down", {15'h0, key_down}, 16'h1);
    pressed = 16'h0;
    wait_ticks(6);
    check("clean_rel_down", {15'h0, key_down}, 16'h0);
    check("clean_rel_code", {12'h0, key_code}, 16'h9);
    check("clean_rel_model_down", {15'h0, exp_down}, 16'h0);

    // Asynchronous reset while scanning
    pressed = 16'h1 << 3;
    for (int k = 0; k < 60 && col_out != 4'b1101; k++) @(negedge clk);
    check("scan_reached_col1", {12'h0, col_out}, 16'hD);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_col_out", {12'h0, col_out}, 16'h0);
    check("midrst_key_code", {12'h0, key_code}, 16'h0);
    check("midrst_key_valid", {15'h0, key_valid}, 16'h0);
    check("midrst_key_down", {15'h0, key_down}, 16'h0);
    pressed = 16'h0;
    repeat (2) @(negedge clk);
    pulses = 0;
    #2 rst_n = 1'b1;
    wait_ticks(3);
    check("rst_exit_pulses", pulses[15:0], 16'd0);
    check("rst_exit_idle", {12'h0, col_out}, 16'h0);

    // Press bounce on row 1, col 1
    pulses = 0;
    for (int t = 0; t < 6; t++) begin
      pressed = (t % 2 == 0) ? (16'h1 << 5) : 16'h0;
      wait_ticks(1);
    end
    check("bounce_no_pulse", pulses[15:0], 16'd0);
    pressed = 16'h1 << 5;
    wait_pulse("bounce");
    wait_ticks(1);
    check("bounce_pulses", pulses[15:0], 16'd1);
    check("bounce_code", {12'h0, key_code}, 16'h5);

    // Release bounce while held
    pulses = 0;
    pressed = 16'h0;
    wait_ticks(2);
    pressed = 16'h1 << 5;
    wait_ticks(3);
    check("relbounce_down", {15'h0, key_down}, 16'h1);
    check("relbounce_model_down", {15'h0, exp_down}, 16'h1);
    check("relbounce_pulses", pulses[15:0], 16'd0);
    pressed = 16'h0;
    wait_ticks(8);

    // Simultaneous keys
    pressed = (16'h1 << 14) | (16'h1 << 2);
    wait_pulse("simul_a");
    check("simul_a_code", {12'h0, key_code}, 16'h2);
    pressed = 16'h0;
    wait_ticks(8);
    pressed = (16'h1 << 4) | (16'h1 << 3);
    wait_pulse("simul_b");
    check("simul_b_code", {12'h0, key_code}, 16'h4);
    pressed = 16'h0;
    wait_ticks(8);

    // Held key F for 11 ticks after the press report
    pulses = 0;
    pressed = 16'h1 << 15;
    wait_pulse("hold");
    repeat (11 * TICK_CLKS + 1) @(negedge clk);
    pressed = 16'h0;
    wait_ticks(8);
`ifdef KEYPAD_REPEAT_EN
    check("hold_pulses", pulses[15:0], 16'd5);
`else
    check("hold_pulses", pulses[15:0], 16'd1);
`endif
    check("hold_code", {12'h0, key_code}, 16'hF);

    // Randomized presses with occasional bounce
    for (int i = 0; i < 50; i++) begin
      logic [15:0] m;
      int hold;
      m = 16'h1 << $urandom_range(15, 0);
      if ($urandom_range(3, 0) == 0) m = m | (16'h1 << $urandom_range(15, 0));
      hold = $urandom_range(14, 1);
      for (int t = 0; t < hold; t++) begin
        pressed = ($urandom_range(5, 0) == 0) ? 16'h0 : m;
        wait_ticks(1);
      end
      pressed = 16'h0;
      wait_ticks($urandom_range(8, 1));
    end
    wait_ticks(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
